// File: rtl/mem_datos_resp.sv
// Data-memory responder: word-addressed RAM with programmable wait states,
// CPU stall generation and a lower-priority DMA port.
module mem_datos_resp #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic [31:0] direccion,
  input  logic [31:0] dato_entrada,
  output logic [31:0] D0,
  output logic        Check_out,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_dir,
  input  logic [31:0] dma_dato,
  output logic        dma_ack,
  output logic [31:0] dma_dato_out
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(WAIT);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_DONE,
    DMA_ACC,
    DMA_DONE
  } state_t;

  logic [DATA_W-1:0] ram [DEPTH];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] wdata;

  logic cpu_req;
  logic access;
  logic ram_we;
  logic unused_bits;

  assign cpu_req = MEM_RD | MEM_WR;
  assign access  = ((state == CPU_ACC) || (state == DMA_ACC)) && (cnt == '0);
  assign ram_we  = access && op_wr;

  // Address bits outside the word index are intentionally ignored (aliasing).
  assign unused_bits = ^{direccion[1:0], direccion[31:ADDR_W+2],
                         dma_dir[1:0], dma_dir[31:ADDR_W+2]};

  // Stall the CPU while its access is pending or while it waits behind DMA.
  assign Check_out = (state == CPU_ACC) ||
                     (((state == IDLE) || (state == DMA_ACC) || (state == DMA_DONE)) && cpu_req);

  // RAM write port; contents survive reset, and reset kills a pending write.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= wdata;
  end

  // Access sequencer: arbitration, wait-state countdown and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_wr        <= 1'b0;
      idx          <= '0;
      wdata        <= '0;
      D0           <= '0;
      dma_dato_out <= '0;
      dma_ack      <= 1'b0;
    end else begin
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            op_wr <= MEM_WR;
            idx   <= direccion[ADDR_W+1:2];
            wdata <= dato_entrada;
            cnt   <= WAIT_V;
            state <= CPU_ACC;
          end else if (dma_req) begin
            op_wr <= dma_wr;
            idx   <= dma_dir[ADDR_W+1:2];
            wdata <= dma_dato;
            cnt   <= WAIT_V;
            state <= DMA_ACC;
          end
        end
        CPU_ACC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!op_wr) D0 <= ram[idx];
            state <= CPU_DONE;
          end
        end
        CPU_DONE: state <= IDLE;
        DMA_ACC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!op_wr) dma_dato_out <= ram[idx];
            dma_ack <= 1'b1;
            state   <= DMA_DONE;
          end
        end
        DMA_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_datos_resp.sv
// Self-checking bench for mem_datos_resp: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-timing model.
module tb_mem_datos_resp;

  localparam int unsigned AW = 8;
  localparam int unsigned WT = 2;
  localparam int unsigned NW = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MEM_RD = 1'b0;
  logic        MEM_WR = 1'b0;
  logic [31:0] direccion = '0;
  logic [31:0] dato_entrada = '0;
  logic [31:0] D0;
  logic        Check_out;
  logic        dma_req = 1'b0;
  logic        dma_wr = 1'b0;
  logic [31:0] dma_dir = '0;
  logic [31:0] dma_dato = '0;
  logic        dma_ack;
  logic [31:0] dma_dato_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_datos_resp #(.ADDR_W(AW), .WAIT(WT)) dut (
    .clk(clk), .rst_n(rst_n), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .direccion(direccion), .dato_entrada(dato_entrada), .D0(D0),
    .Check_out(Check_out), .dma_req(dma_req), .dma_wr(dma_wr),
    .dma_dir(dma_dir), .dma_dato(dma_dato), .dma_ack(dma_ack),
    .dma_dato_out(dma_dato_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % NW);
  endfunction

  // Model: an accepted access occupies WT+1 cycles, takes effect in the last
  // one, then one done cycle. owner 0 = free, 1 = CPU, 2 = DMA.
  logic [31:0] m_mem [NW];
  bit          m_known [NW];
  int          owner = 0;
  int          age = 0;
  bit          l_wr;
  int          l_idx;
  logic [31:0] l_data;
  logic [31:0] m_d0 = '0;
  bit          m_d0_known = 1'b1;
  logic [31:0] m_dout = '0;
  bit          m_dout_known = 1'b1;

  // Compare DUT outputs with the model each cycle, then advance the model.
  always @(negedge clk) begin
    bit creq;
    bit exp_chk;
    bit exp_ack;
    creq = MEM_RD | MEM_WR;
    if (!rst_n) begin
      owner = 0; age = 0;
      m_d0 = '0; m_d0_known = 1'b1;
      m_dout = '0; m_dout_known = 1'b1;
    end
    if (owner == 1) exp_chk = (age <= int'(WT) + 1);
    else            exp_chk = creq;
    exp_ack = (owner == 2) && (age == int'(WT) + 2);
    check("check_out", 32'(Check_out), 32'(exp_chk));
    check("dma_ack", 32'(dma_ack), 32'(exp_ack));
    if (m_d0_known)   check("d0", D0, m_d0);
    if (m_dout_known) check("dma_dato_out", dma_dato_out, m_dout);
    if (rst_n) begin
      if (owner == 0) begin
        if (creq) begin
          owner = 1; age = 1; l_wr = MEM_WR; l_idx = widx(direccion); l_data = dato_entrada;
        end else if (dma_req) begin
          owner = 2; age = 1; l_wr = dma_wr; l_idx = widx(dma_dir); l_data = dma_dato;
        end
      end else if (age == int'(WT) + 1) begin
        if (l_wr) begin
          m_mem[l_idx] = l_data; m_known[l_idx] = 1'b1;
        end else if (owner == 1) begin
          m_d0 = m_mem[l_idx]; m_d0_known = m_known[l_idx];
        end else begin
          m_dout = m_mem[l_idx]; m_dout_known = m_known[l_idx];
        end
        age++;
      end else if (age == int'(WT) + 2) begin
        owner = 0; age = 0;
      end else begin
        age++;
      end
    end
  end

  // CPU access held until the stall drops; returns D0 and stall length.
  task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] q,
                            output int hi, output int t_done, output bit first_hi);
    bit done;
    @(posedge clk); #1;
    MEM_RD = rd; MEM_WR = wr; direccion = a; dato_entrada = d;
    hi = 0; done = 1'b0; t_done = -1; first_hi = 1'b0; q = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) first_hi = Check_out;
      if (Check_out) hi++;
      else begin
        done = 1'b1; t_done = cyc; q = D0;
        break;
      end
    end
    check("cpu_done_in_time", 32'(done), 32'd1);
    @(posedge clk); #1;
    MEM_RD = 1'b0; MEM_WR = 1'b0;
  endtask

  // DMA access held until the ack pulse; returns read data and ack cycle.
  task automatic dma_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] q, output int t_ack);
    bit done;
    @(posedge clk); #1;
    dma_req = 1'b1; dma_wr = wr; dma_dir = a; dma_dato = d;
    done = 1'b0; t_ack = -1; q = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dma_ack) begin
        done = 1'b1; t_ack = cyc; q = dma_dato_out;
        break;
      end
    end
    check("dma_ack_in_time", 32'(done), 32'd1);
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  initial begin
    logic [31:0] q, qd;
    int hi, td, ta;
    bit fh;
    logic [9:0] pat;
    logic [31:0] qa, qb;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_d0", D0, 32'h0);
    check("rst_check_out", 32'(Check_out), 32'd0);
    check("rst_dma_ack", 32'(dma_ack), 32'd0);
    check("rst_dma_out", dma_dato_out, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Write then read back
    cpu_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, q, hi, td, fh);
    check("wr_stall_len", 32'(hi), 32'd4);
    cpu_access(1'b1, 1'b0, 32'h10, 32'h0, q, hi, td, fh);
    check("rd_stall_len", 32'(hi), 32'd4);
    check("rd_data", q, 32'hDEADBEEF);

    // Held back-to-back reads
    cpu_access(1'b0, 1'b1, 32'h0, 32'h11, q, hi, td, fh);
    cpu_access(1'b0, 1'b1, 32'h4, 32'h22, q, hi, td, fh);
    @(posedge clk); #1; MEM_RD = 1'b1; direccion = 32'h0;
    qa = '0; qb = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[9-i] = Check_out;
      if (i == 4) begin
        qa = D0;
        @(posedge clk); #1; direccion = 32'h4;
      end
      if (i == 9) qb = D0;
    end
    @(posedge clk); #1; MEM_RD = 1'b0;
    check("held_pattern", 32'(pat), 32'(10'b1111011110));
    check("held_first", qa, 32'h11);
    check("held_second", qb, 32'h22);

    // Simultaneous CPU and DMA requests: CPU first
    fork
      cpu_access(1'b1, 1'b0, 32'h0, 32'h0, q, hi, td, fh);
      dma_access(1'b1, 32'h8, 32'h55, qd, ta);
    join
    check("sim_cpu_data", q, 32'h11);
    check("sim_ack_delay", 32'(ta - td), 32'd5);
    cpu_access(1'b1, 1'b0, 32'h8, 32'h0, q, hi, td, fh);
    check("sim_word2", q, 32'h55);

    // CPU arrives during a DMA access to the same word
    fork
      dma_access(1'b1, 32'hC, 32'h77, qd, ta);
      begin
        repeat (2) @(posedge clk);
        cpu_access(1'b0, 1'b1, 32'hC, 32'h99, q, hi, td, fh);
      end
    join
    check("mid_dma_first_stall", 32'(fh), 32'd1);
    check("mid_dma_stall_len", 32'(hi), 32'd7);
    check("mid_dma_order", 32'(td - ta), 32'd5);
    cpu_access(1'b1, 1'b0, 32'hC, 32'h0, q, hi, td, fh);
    check("mid_dma_final", q, 32'h99);

    // RD+WR together is a write; address aliasing
    cpu_access(1'b1, 1'b1, 32'h403, 32'hA5A5, q, hi, td, fh);
    check("rdwr_d0_unchanged", q, 32'h99);
    cpu_access(1'b1, 1'b0, 32'h000, 32'h0, q, hi, td, fh);
    check("alias_read", q, 32'hA5A5);

    // DMA read of a known word
    dma_access(1'b0, 32'h10, 32'h0, qd, ta);
    check("dma_read", qd, 32'hDEADBEEF);

    // Reset during a write with one wait state left
    cpu_access(1'b0, 1'b1, 32'h14, 32'h1234, q, hi, td, fh);
    @(posedge clk); #1; MEM_WR = 1'b1; direccion = 32'h14; dato_entrada = 32'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b0; MEM_WR = 1'b0;
    @(negedge clk);
    check("rst_mid_check_out", 32'(Check_out), 32'd0);
    check("rst_mid_d0", D0, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    cpu_access(1'b1, 1'b0, 32'h14, 32'h0, q, hi, td, fh);
    check("rst_mid_kept", q, 32'h1234);

    // Random traffic on a small word set with aliased addresses
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      MEM_RD       = ($urandom_range(0, 99) < 25);
      MEM_WR       = ($urandom_range(0, 99) < 15);
      direccion    = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      dato_entrada = $urandom();
      dma_req      = ($urandom_range(0, 99) < 40);
      dma_wr       = $urandom_range(0, 1) == 1;
      dma_dir      = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      dma_dato     = $urandom();
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    @(posedge clk); #1;
    MEM_RD = 1'b0; MEM_WR = 1'b0; dma_req = 1'b0; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
